// File: rtl/memarb_pkg.sv
// Shared types and defaults for the two-master SRAM arbiter.
// Round-robin arbitration is enabled by defining MEMARB_RR_EN; otherwise m0 has fixed priority.
package memarb_pkg;

  localparam int unsigned MEMARB_AW = 16;
  localparam int unsigned MEMARB_DW = 16;

  typedef enum logic {
    MA_M0 = 1'b0,
    MA_M1 = 1'b1
  } memarb_id_t;

  // Master index of a one-hot grant vector; an empty vector maps to MA_M0.
  function automatic memarb_id_t memarb_winner(input logic [1:0] gnt);
    return gnt[1] ? MA_M1 : MA_M0;
  endfunction

endpackage

// File: rtl/memarb_pick2.sv
// Two-requester picker producing a one-hot grant vector.
// With MEMARB_RR_EN a priority flop alternates the favoured requester; without it req[0] always wins.
module memarb_pick2
  import memarb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef MEMARB_RR_EN
  // prio_q = 0 favours requester 0, 1 favours requester 1.
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    // After any grant the non-winner becomes favoured.
    if (gnt[0]) begin
      prio_d = 1'b1;
    end else if (gnt[1]) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`else
  // Fixed priority keeps no state; clk and rst_n are kept for a uniform port list.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    gnt    = 2'b00;
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two bus masters onto the single write port and single read port of the SRAM.
// MEMARB_RR_EN selects round-robin per port; the default build gives m0 fixed priority.
module mem_arbiter
  import memarb_pkg::*;
#(
  parameter int unsigned AW = MEMARB_AW,
  parameter int unsigned DW = MEMARB_DW
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic [AW-1:0] mem_waddr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_raddr_o,
  output logic          mem_re_o,
  input  logic [DW-1:0] mem_rdata_i
);

  logic [1:0] wr_req;
  logic [1:0] rd_req;
  logic [1:0] wr_gnt;
  logic [1:0] rd_gnt;

  logic       rd_pend_q;
  logic       rd_pend_d;
  memarb_id_t rd_owner_q;
  memarb_id_t rd_owner_d;

  // Requests are masked during reset so no grant or strobe can escape.
  always_comb begin
    wr_req = 2'b00;
    rd_req = 2'b00;
    if (rst_n) begin
      wr_req = {m1_req & m1_we, m0_req & m0_we};
      rd_req = {m1_req & ~m1_we, m0_req & ~m0_we};
    end
  end

  memarb_pick2 u_pick_wr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (wr_req),
    .gnt   (wr_gnt)
  );

  memarb_pick2 u_pick_rd (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rd_req),
    .gnt   (rd_gnt)
  );

  // A master never requests both ports at once, so at most one of each pair is set.
  assign m0_gnt = wr_gnt[0] | rd_gnt[0];
  assign m1_gnt = wr_gnt[1] | rd_gnt[1];

  always_comb begin
    mem_we_o    = 1'b0;
    mem_waddr_o = '0;
    mem_wdata_o = '0;
    unique case (wr_gnt)
      2'b01: begin
        mem_we_o    = 1'b1;
        mem_waddr_o = m0_addr;
        mem_wdata_o = m0_wdata;
      end
      2'b10: begin
        mem_we_o    = 1'b1;
        mem_waddr_o = m1_addr;
        mem_wdata_o = m1_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    mem_re_o    = 1'b0;
    mem_raddr_o = '0;
    unique case (rd_gnt)
      2'b01: begin
        mem_re_o    = 1'b1;
        mem_raddr_o = m0_addr;
      end
      2'b10: begin
        mem_re_o    = 1'b1;
        mem_raddr_o = m1_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_pend_d  = |rd_gnt;
    rd_owner_d = rd_owner_q;
    if (|rd_gnt) begin
      rd_owner_d = memarb_winner(rd_gnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= MA_M0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // SRAM read data lands one cycle after the granting edge; only the owner sees rvalid.
  assign m0_rvalid = rst_n & rd_pend_q & (rd_owner_q == MA_M0);
  assign m1_rvalid = rst_n & rd_pend_q & (rd_owner_q == MA_M1);
  assign m0_rdata  = mem_rdata_i;
  assign m1_rdata  = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural read-before-write SRAM (4K words).
// Contention expectations follow MEMARB_RR_EN when it is defined.
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_waddr_o, mem_raddr_o;
  logic [DW-1:0] mem_wdata_o;
  logic          mem_we_o, mem_re_o;
  logic [DW-1:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .m0_req      (m0_req),
    .m0_we       (m0_we),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_gnt      (m0_gnt),
    .m0_rvalid   (m0_rvalid),
    .m0_rdata    (m0_rdata),
    .m1_req      (m1_req),
    .m1_we       (m1_we),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_gnt      (m1_gnt),
    .m1_rvalid   (m1_rvalid),
    .m1_rdata    (m1_rdata),
    .mem_waddr_o (mem_waddr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_we_o    (mem_we_o),
    .mem_raddr_o (mem_raddr_o),
    .mem_re_o    (mem_re_o),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: registered read, read-before-write, low 12 address bits decoded.
  logic [DW-1:0] sram [0:4095];
  always @(posedge clk) begin
    if (mem_re_o) mem_rdata_i <= sram[mem_raddr_o[11:0]];
    if (mem_we_o) sram[mem_waddr_o[11:0]] <= mem_wdata_o;
  end

  typedef struct {
    logic          m0_req, m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m1_req, m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          e_m0_gnt, e_m1_gnt, e_we, e_re;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic [AW-1:0] e_raddr;
    logic          e_m0_rv, e_m1_rv;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  logic exp_m1_win;
  logic prev_valid;
  logic prev_m1;

  initial begin
    //          m0: req we addr    wdata    m1: req we addr    wdata    gnt0 gnt1 we re waddr    wdata    raddr    rv0 rv1 rdata
    vecs[0]  = '{1, 1, 16'h0010, 16'hA5A5, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0010, 16'hA5A5, 16'h0000, 0, 0, 16'h0000};
    vecs[1]  = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0030, 16'h3030, 0, 1, 1, 0, 16'h0030, 16'h3030, 16'h0000, 0, 0, 16'h0000};
    vecs[2]  = '{1, 1, 16'h0040, 16'h1111, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 0, 16'h0040, 16'h1111, 16'h0000, 0, 0, 16'h0000};
    vecs[3]  = '{1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h0000, 16'h0010, 0, 0, 16'h0000};
    vecs[4]  = '{1, 1, 16'h0020, 16'hBEEF, 1, 0, 16'h0030, 16'h0000, 1, 1, 1, 1, 16'h0020, 16'hBEEF, 16'h0030, 1, 0, 16'hA5A5};
    vecs[5]  = '{1, 1, 16'h0040, 16'h2222, 1, 0, 16'h0040, 16'h0000, 1, 1, 1, 1, 16'h0040, 16'h2222, 16'h0040, 0, 1, 16'h3030};
    vecs[6]  = '{0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h0000, 0, 1, 0, 1, 16'h0000, 16'h0000, 16'h0040, 0, 1, 16'h1111};
    vecs[7]  = '{1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h0000, 16'h0020, 0, 1, 16'h2222};
    vecs[8]  = '{1, 0, 16'h0020, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h0000, 16'h0020, 1, 0, 16'hBEEF};
    vecs[9]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'hBEEF};
    vecs[10] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000};
    vecs[11] = '{0, 0, 16'h0000, 16'h0000, 1, 1, 16'h1010, 16'h7777, 0, 1, 1, 0, 16'h1010, 16'h7777, 16'h0000, 0, 0, 16'h0000};
    vecs[12] = '{1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 1, 16'h0000, 16'h0000, 16'h0010, 0, 0, 16'h0000};
    vecs[13] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h7777};

    // Reset with both masters requesting: nothing may be granted or strobed.
    rst_n = 1'b0;
    drive(1, 0, 16'h0010, 16'h0000, 1, 1, 16'h0030, 16'h1234);
    #2;
    chk("rst_m0_gnt", m0_gnt, 1'b0);
    chk("rst_m1_gnt", m1_gnt, 1'b0);
    chk("rst_we", mem_we_o, 1'b0);
    chk("rst_re", mem_re_o, 1'b0);
    chk("rst_m0_rvalid", m0_rvalid, 1'b0);
    chk("rst_m1_rvalid", m1_rvalid, 1'b0);
    @(negedge clk);
    drive(1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0030, 16'h0000);
    #1;
    chk("rst_rd_both_gnt", {m0_gnt, m1_gnt, mem_re_o}, 3'b000);
    @(negedge clk);
    drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(vecs[i].m0_req, vecs[i].m0_we, vecs[i].m0_addr, vecs[i].m0_wdata,
            vecs[i].m1_req, vecs[i].m1_we, vecs[i].m1_addr, vecs[i].m1_wdata);
      #1;
      chk($sformatf("v%0d_m0_gnt", i), m0_gnt, vecs[i].e_m0_gnt);
      chk($sformatf("v%0d_m1_gnt", i), m1_gnt, vecs[i].e_m1_gnt);
      chk($sformatf("v%0d_we", i), mem_we_o, vecs[i].e_we);
      chk($sformatf("v%0d_re", i), mem_re_o, vecs[i].e_re);
      chk($sformatf("v%0d_waddr", i), mem_waddr_o, vecs[i].e_waddr);
      chk($sformatf("v%0d_wdata", i), mem_wdata_o, vecs[i].e_wdata);
      chk($sformatf("v%0d_raddr", i), mem_raddr_o, vecs[i].e_raddr);
      chk($sformatf("v%0d_m0_rvalid", i), m0_rvalid, vecs[i].e_m0_rv);
      chk($sformatf("v%0d_m1_rvalid", i), m1_rvalid, vecs[i].e_m1_rv);
      if (vecs[i].e_m0_rv) chk($sformatf("v%0d_m0_rdata", i), m0_rdata, vecs[i].e_rdata);
      if (vecs[i].e_m1_rv) chk($sformatf("v%0d_m1_rdata", i), m1_rdata, vecs[i].e_rdata);
    end

    // Reset mid-read: m0 read moves read priority to m1, then m1's granted read is killed.
    @(negedge clk);
    drive(1, 0, 16'h0010, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    #1;
    chk("mr_m0_gnt", m0_gnt, 1'b1);
    @(negedge clk);
    drive(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0030, 16'h0000);
    #1;
    chk("mr_m1_gnt", m1_gnt, 1'b1);
    chk("mr_m0_rvalid", m0_rvalid, 1'b1);
    chk("mr_m0_rdata", m0_rdata, 16'h7777);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mr_rst_m1_gnt", m1_gnt, 1'b0);
    chk("mr_rst_re", mem_re_o, 1'b0);
    chk("mr_rst_m0_rvalid", m0_rvalid, 1'b0);
    @(negedge clk);
    drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr_rel_m1_rvalid", m1_rvalid, 1'b0);
    chk("mr_rel_m0_rvalid", m0_rvalid, 1'b0);
    @(negedge clk);
    #1;
    chk("mr_rel2_m1_rvalid", m1_rvalid, 1'b0);

    // Read contention: m0 wins first after reset in either build.
    prev_valid = 1'b0;
    prev_m1    = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0030, 16'h0000);
      #1;
`ifdef MEMARB_RR_EN
      exp_m1_win = (c % 2) == 1;
`else
      exp_m1_win = 1'b0;
`endif
      chk($sformatf("rc%0d_m0_gnt", c), m0_gnt, !exp_m1_win);
      chk($sformatf("rc%0d_m1_gnt", c), m1_gnt, exp_m1_win);
      chk($sformatf("rc%0d_raddr", c), mem_raddr_o, exp_m1_win ? 16'h0030 : 16'h0010);
      chk($sformatf("rc%0d_m0_rvalid", c), m0_rvalid, prev_valid & !prev_m1);
      chk($sformatf("rc%0d_m1_rvalid", c), m1_rvalid, prev_valid & prev_m1);
      if (prev_valid) chk($sformatf("rc%0d_rdata", c), m0_rdata, prev_m1 ? 16'h3030 : 16'h7777);
      prev_valid = 1'b1;
      prev_m1    = exp_m1_win;
    end

    // Write contention for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive(1, 1, 16'h0100, 16'h0001, 1, 1, 16'h0200, 16'h0002);
      #1;
`ifdef MEMARB_RR_EN
      exp_m1_win = (c % 2) == 1;
`else
      exp_m1_win = 1'b0;
`endif
      chk($sformatf("wc%0d_m0_gnt", c), m0_gnt, !exp_m1_win);
      chk($sformatf("wc%0d_m1_gnt", c), m1_gnt, exp_m1_win);
      chk($sformatf("wc%0d_waddr", c), mem_waddr_o, exp_m1_win ? 16'h0200 : 16'h0100);
      chk($sformatf("wc%0d_re", c), mem_re_o, 1'b0);
    end

    @(negedge clk);
    drive(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    #1;
    chk("end_idle_we", mem_we_o, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that shares the single-clock dual-port `sram` (one write port, one read port, registered read data) between the `cpu` and a second bus master (debug/DMA). Each SRAM port is arbitrated independently, so one read and one write retire every cycle when the masters request different port types. It sits between the masters and `sram` in `top`, replacing the direct CPU-to-SRAM wiring.

## Interface
- `AW`, 16, address width passed through to SRAM.
- `DW`, 16, data width.
- `clk` in 1: the single clock; all state on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `m0_req` / `m1_req` in 1: master requests an access; must hold until granted.
- `m0_we` / `m1_we` in 1: 1 = write, 0 = read; stable while req is high.
- `m0_addr` / `m1_addr` in AW: access address; stable while req is high.
- `m0_wdata` / `m1_wdata` in DW: write data; stable while req is high.
- `m0_gnt` / `m1_gnt` out 1: access accepted this cycle (req & gnt = transfer).
- `m0_rvalid` / `m1_rvalid` out 1: read data valid for this master.
- `m0_rdata` / `m1_rdata` out DW: read data; meaningful only with rvalid.
- `mem_waddr_o`, `mem_wdata_o` out AW/DW; `mem_we_o` out 1: SRAM write port.
- `mem_raddr_o` out AW; `mem_re_o` out 1; `mem_rdata_i` in DW: SRAM read port.

## Operation
- Requests are classed as write (`we`=1) or read (`we`=0). Write port and read port each have their own 2-way arbiter.
- Different classes (one read, one write): both granted in the same cycle.
- Same class: one winner per arbiter per cycle; loser's gnt stays 0, and it holds its request.
- Priority state per arbiter: one flop `prio` (0 = m0 favored). On any grant by that arbiter, `prio` points to the non-winner. Reset value 0 on both.
- Granted write: `mem_we_o`=1, waddr/wdata muxed from winner, same cycle.
- Granted read: `mem_re_o`=1, raddr muxed from winner; `rd_owner` flop records winner, `rd_pend` flop set.
- Next cycle: `mN_rvalid`=1 only for `rd_owner` when `rd_pend`=1; both `mN_rdata` = `mem_rdata_i`.
- Same-address read and write in one cycle: read returns pre-write data (SRAM read-before-write); no forwarding.
- Address is passed at full AW; SRAM decodes low 12 bits, so aliasing above 4K words is expected.
- Unselected mux outputs are driven 0 when the corresponding strobe is low.
- Reset (async assert): `rd_pend`=0, `rd_owner`=0, both `prio`=0. While `rst_n`=0, all gnt, rvalid, `mem_we_o` and `mem_re_o` are 0. A read in flight at reset is dropped with no rvalid.

## Timing
- gnt and SRAM strobes are combinational from req/we/prio, with zero cycles from request to grant.
- Read latency: rvalid exactly 1 cycle after the granting edge.
- Throughput: 1 read + 1 write per cycle aggregate; 1 access per master per cycle.
- The only path from `mem_rdata_i` is the pass-through to rdata. No path exists from rvalid/rdata back into gnt.
- Back-to-back reads by one master are allowed; rvalid is then high on consecutive cycles.

## Configuration
- `MEMARB_RR_EN` defined: round-robin as above.
- Not defined: fixed priority, where m0 (CPU) always wins contests, m1 waits indefinitely, and the `prio` flops are not built. All other behaviour is identical.

## Structure
- Package `memarb_pkg`: `AW`/`DW` defaults and the master index enum `memarb_id_t {MA_M0, MA_M1}` used for `rd_owner`.
- Sub-module `memarb_pick2`: 2-requester picker (req[1:0] -> gnt[1:0] one-hot, plus priority flop under `MEMARB_RR_EN`). It is instantiated twice, once for reads and once for writes.

## Test plan
- Reset: hold `rst_n`=0 with both reqs high -> all gnt/rvalid/strobes 0. Release, m0 read 0x0010 -> gnt same cycle, m0_rvalid next cycle with stored value, m1_rvalid 0.
- Dual issue: m0 write 0x0020←0xBEEF, m1 read 0x0030 same cycle -> both gnt=1, `mem_we_o`=`mem_re_o`=1, m1_rvalid next cycle.
- Read contention (RR): both read continuously -> grants alternate m0,m1,m0,…; each rvalid pairs with its own read.
- Fixed priority (no macro): both write continuously for 10 cycles -> m0 granted every cycle, m1_gnt never asserts.
- Same-address collision: memory holds 0x1111 at 0x0040; m0 writes 0x2222 and m1 reads 0x0040 same cycle -> m1_rdata 0x1111; re-read -> 0x2222.
- Reset mid-read: grant m1 read, assert `rst_n` low before next edge -> no m1_rvalid after release, `prio` back to 0.
